// File: rtl/carus_cg_pkg.sv
// Shared types and constants for the Carus clock-gating sequencer.
package carus_cg_pkg;

  // Sequencer states: clock running (ACTIVE, IDLE, WAKE) or stopped (GATED)
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    IDLE   = 2'd1,
    GATED  = 2'd2,
    WAKE   = 2'd3
  } cg_state_e;

  // Wake settle counter only needs to reach 15
  localparam int WAKE_CNT_W = 4;

  // Default idle threshold while the programmable threshold is not in use
  localparam int RST_THR_DEFAULT = 16;

  // Default number of running cycles before a pending request is granted
  localparam int WAKE_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/carus_cg_ctrl.sv
// Carus automatic clock-gating sequencer.
// Runs on the always-on clock and drives the enable of an external clock-gate
// cell. Gates the Carus clock after a programmable idle period and re-opens it
// on demand, holding off bus grants until the clock has settled.
// Optional build macro CARUS_CG_STATS_EN adds a saturating gated-cycle counter
// (gated_cnt_o) with a synchronous clear (stats_clr_i).
module carus_cg_ctrl
  import carus_cg_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEFAULT,
  parameter int RST_THR     = RST_THR_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cg_auto_i,
  input  logic             force_on_i,
  input  logic [CNT_W-1:0] idle_thr_i,
  input  logic             busy_i,
  input  logic             req_i,
  output logic             gnt_o,
  output logic             cg_en_o,
  output logic             gated_o
`ifdef CARUS_CG_STATS_EN
  ,
  input  logic             stats_clr_i,
  output logic [31:0]      gated_cnt_o
`endif
);

  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      RST_THR_W = CNT_W'(RST_THR);
  localparam logic [WAKE_CNT_W-1:0] WCNT_ONE  = WAKE_CNT_W'(1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

  cg_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [WAKE_CNT_W-1:0] wcnt;
  logic                  wake;
  logic [CNT_W-1:0]      thr_sel;
  logic [CNT_W-1:0]      thr_last;

  // Any reason to keep (or bring back) the clock
  assign wake = req_i | busy_i | force_on_i | ~cg_auto_i;

  // Last idle count before gating; a zero threshold behaves as one
  assign thr_sel  = cg_auto_i ? idle_thr_i : RST_THR_W;
  assign thr_last = (thr_sel == '0) ? '0 : (thr_sel - CNT_ONE);

  // Grants only while fully ACTIVE; combinational so a held request sees it at once
  assign gnt_o = req_i & (state == ACTIVE) & ~rst_i;

  // Sequencer FSM; cg_en_o / gated_o are registered copies of the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ACTIVE;
      cnt     <= '0;
      wcnt    <= '0;
      cg_en_o <= 1'b1;
      gated_o <= 1'b0;
    end else begin
      cg_en_o <= 1'b1;
      gated_o <= 1'b0;
      case (state)
        ACTIVE: begin
          if (!wake) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        IDLE: begin
          if (wake) begin
            state <= ACTIVE;
          end else if (cnt == thr_last) begin
            state   <= GATED;
            cg_en_o <= 1'b0;
            gated_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        GATED: begin
          if (wake) begin
            state <= WAKE;
            wcnt  <= '0;
          end else begin
            cg_en_o <= 1'b0;
            gated_o <= 1'b1;
          end
        end
        WAKE: begin
          // Wake always runs to completion, even if the request goes away
          wcnt <= wcnt + WCNT_ONE;
          if (wcnt == WAKE_LAST) begin
            state <= ACTIVE;
          end
        end
        default: begin
          state <= ACTIVE;
        end
      endcase
    end
  end

`ifdef CARUS_CG_STATS_EN
  // Saturating count of gated cycles; clear wins over increment
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      gated_cnt_o <= '0;
    end else if (gated_o && (gated_cnt_o != 32'hFFFF_FFFF)) begin
      gated_cnt_o <= gated_cnt_o + 32'd1;
    end
  end
`endif

endmodule
